// File: rtl/row_pack_writer_if.sv
// row_pack_writer_if: pixel byte stream (valid/ready) plus wide row-write memory bus
// Ports: pix_valid/pix_data/pix_sof/pix_ready = byte stream; mem_en/mem_rw/mem_abus/mem_wdata/mem_grant = row write
interface row_pack_writer_if #(
    parameter int ROW_W = 50
);
    logic               pix_valid;
    logic [7:0]         pix_data;
    logic               pix_sof;
    logic               pix_ready;
    logic               mem_en;
    logic               mem_rw;
    logic [15:0]        mem_abus;
    logic [8*ROW_W-1:0] mem_wdata;
    logic               mem_grant;
    modport slave (
        input  pix_valid, pix_data, pix_sof, mem_grant,
        output pix_ready, mem_en, mem_rw, mem_abus, mem_wdata
    );
    modport master (
        output pix_valid, pix_data, pix_sof, mem_grant,
        input  pix_ready, mem_en, mem_rw, mem_abus, mem_wdata
    );
endinterface

// File: rtl/row_pack_writer.sv
// row_pack_writer: packs a byte stream into ROW_W-byte rows and writes each full row as one wide memory burst
// Ports: clk, reset (sync, active-high); bus = pixel stream in / row-write memory bus out;
//        row_done_o, frame_done_o = pulses after a row / the last frame row is written; row_idx_o = last written row
module row_pack_writer #(
    parameter int          ROW_W     = 50,
    parameter int          ROWS      = 20,
    parameter logic [15:0] BASE_ADDR = 16'd0
) (
    input  logic             clk,
    input  logic             reset,
    row_pack_writer_if.slave bus,
    output logic             row_done_o,
    output logic             frame_done_o,
    output logic [7:0]       row_idx_o
);
    localparam int IW = $clog2(ROW_W);
    typedef enum logic {IDLE, WRITE} state_t;
    state_t             state_q, state_d;
    logic [8*ROW_W-1:0] data_q [2];
    logic [15:0]        addr_q [2];
    logic [7:0]         rnum_q [2];
    logic [1:0]         pend_q, pend_d;
    logic               fill_sel_q, fill_sel_d, wr_sel_q, wr_sel_d;
    logic [IW-1:0]      fill_idx_q, fill_idx_d;
    logic [7:0]         row_cnt_q, row_cnt_d;
    logic [15:0]        row_addr_q, row_addr_d;
    logic               row_done_q, frame_done_q;
    logic [7:0]         row_idx_q;
    logic               acc, last, grant, wrap, wr;
    logic [IW-1:0]      idx;
    logic [7:0]         cur_cnt;
    logic [15:0]        cur_addr;

    // sof restarts at lane 0 of row 0; the discarded partial row is just overwritten
    assign acc      = bus.pix_valid & bus.pix_ready;
    assign idx      = bus.pix_sof ? '0 : fill_idx_q;
    assign cur_cnt  = bus.pix_sof ? '0 : row_cnt_q;
    assign cur_addr = bus.pix_sof ? BASE_ADDR : row_addr_q;
    assign last     = acc & (idx == IW'(ROW_W - 1));
    assign wrap     = cur_cnt == 8'(ROWS - 1);
    assign wr       = state_q == WRITE;
    assign grant    = wr & bus.mem_grant;

    // buffers complete and drain in the same alternating order, so wr_sel_q always names the oldest pending one
    always_comb begin
        pend_d = pend_q;
        if (grant) pend_d[wr_sel_q] = 1'b0;
        if (last) pend_d[fill_sel_q] = 1'b1;
        fill_idx_d = last ? '0 : acc ? idx + 1'b1 : fill_idx_q;
        fill_sel_d = fill_sel_q ^ last;
        wr_sel_d   = wr_sel_q ^ grant;
        row_cnt_d  = last ? (wrap ? '0 : cur_cnt + 8'd1) : acc ? cur_cnt : row_cnt_q;
        row_addr_d = last ? (wrap ? BASE_ADDR : cur_addr + 16'(ROW_W)) : acc ? cur_addr : row_addr_q;
        // a grant always returns to IDLE so mem_en drops for a cycle between bursts
        state_d = !wr ? (|pend_d ? WRITE : IDLE) : (bus.mem_grant ? IDLE : WRITE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            pend_q       <= '0;
            fill_sel_q   <= 1'b0;
            wr_sel_q     <= 1'b0;
            fill_idx_q   <= '0;
            row_cnt_q    <= '0;
            row_addr_q   <= BASE_ADDR;
            row_done_q   <= 1'b0;
            frame_done_q <= 1'b0;
            row_idx_q    <= '0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            fill_sel_q   <= fill_sel_d;
            wr_sel_q     <= wr_sel_d;
            fill_idx_q   <= fill_idx_d;
            row_cnt_q    <= row_cnt_d;
            row_addr_q   <= row_addr_d;
            row_done_q   <= grant;
            frame_done_q <= grant & (rnum_q[wr_sel_q] == 8'(ROWS - 1));
            if (grant) row_idx_q <= rnum_q[wr_sel_q];
        end
    end

    always_ff @(posedge clk) begin
        if (acc) begin
            data_q[fill_sel_q][8*idx +: 8] <= bus.pix_data;
            if (idx == '0) begin
                addr_q[fill_sel_q] <= cur_addr;
                rnum_q[fill_sel_q] <= cur_cnt;
            end
        end
    end

    assign bus.pix_ready = ~&pend_q;
    assign bus.mem_en    = wr;
    assign bus.mem_rw    = ~wr;
    assign bus.mem_abus  = wr ? addr_q[wr_sel_q] : '0;
    assign bus.mem_wdata = wr ? data_q[wr_sel_q] : '0;
    assign row_done_o    = row_done_q;
    assign frame_done_o  = frame_done_q;
    assign row_idx_o     = row_idx_q;
endmodule

// File: tb/tb_row_pack_writer.sv
// tb_row_pack_writer: scoreboard bench for row_pack_writer
module tb_row_pack_writer;
    localparam int ROW_W = 50;
    localparam int ROWS  = 20;
    typedef struct {
        logic [15:0]        a;
        logic [8*ROW_W-1:0] d;
        logic [7:0]         n;
    } wr_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       row_done, frame_done;
    logic [7:0] row_idx;
    int         total = 0, bad = 0, stalls = 0, fd_cnt = 0;
    logic [7:0] fd_idx = '0;
    wr_t        exp_q[$];
    logic [15:0]        hist_a[$];
    logic [8*ROW_W-1:0] hist_d[$];
    int         m_idx = 0, m_row = 0;
    wr_t        m_cur;

    row_pack_writer_if #(.ROW_W(ROW_W)) bus ();
    row_pack_writer #(.ROW_W(ROW_W), .ROWS(ROWS), .BASE_ADDR(16'd0)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .row_done_o(row_done), .frame_done_o(frame_done), .row_idx_o(row_idx)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, int act, int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endfunction

    function automatic void chkw(string name, logic [8*ROW_W-1:0] act, logic [8*ROW_W-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endfunction

    task automatic model_accept(input logic [7:0] d, input logic sof);
        if (sof) begin
            m_idx = 0;
            m_row = 0;
        end
        if (m_idx == 0) begin
            m_cur.a = 16'(m_row * ROW_W);
            m_cur.n = 8'(m_row);
            m_cur.d = '0;
        end
        m_cur.d[8*m_idx +: 8] = d;
        if (m_idx == ROW_W - 1) begin
            exp_q.push_back(m_cur);
            m_idx = 0;
            m_row = (m_row + 1) % ROWS;
        end else m_idx++;
    endtask

    task automatic send(input logic [7:0] d, input logic sof);
        int t = 0;
        bus.pix_valid = 1'b1;
        bus.pix_data  = d;
        bus.pix_sof   = sof;
        @(negedge clk);
        while (!bus.pix_ready && t < 300) begin
            stalls++;
            t++;
            @(negedge clk);
        end
        if (!bus.pix_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: pix_ready=0 after %0d cycles, want 1", t);
        end else model_accept(d, sof);
        @(posedge clk);
        #1;
        bus.pix_valid = 1'b0;
        bus.pix_sof   = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.pix_valid = 1'b0;
        bus.pix_sof   = 1'b0;
        bus.mem_grant = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_idx = 0;
        m_row = 0;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("drain_queue_empty", exp_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    // monitor: pops the expected row on every accepted write and checks the row_done/frame_done pulse one cycle later
    initial begin
        logic       nrd = 1'b0, nfd = 1'b0;
        logic [7:0] nidx = '0;
        wr_t        e;
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_q.delete();
                nrd = 1'b0;
                nfd = 1'b0;
            end else begin
                if (nrd || row_done) begin
                    chk("row_done", int'(row_done), int'(nrd));
                    if (nrd) chk("row_idx", int'(row_idx), int'(nidx));
                end
                if (nfd || frame_done) chk("frame_done", int'(frame_done), int'(nfd));
                if (frame_done) begin
                    fd_cnt++;
                    fd_idx = row_idx;
                end
                nrd = 1'b0;
                nfd = 1'b0;
                if (bus.mem_en && bus.mem_grant) begin
                    hist_a.push_back(bus.mem_abus);
                    hist_d.push_back(bus.mem_wdata);
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_write: abus=%0d with no row expected", bus.mem_abus);
                    end else begin
                        e = exp_q.pop_front();
                        chk("mem_abus", int'(bus.mem_abus), int'(e.a));
                        chkw("mem_wdata", bus.mem_wdata, e.d);
                        chk("mem_rw", int'(bus.mem_rw), 0);
                        nrd  = 1'b1;
                        nfd  = e.n == 8'(ROWS - 1);
                        nidx = e.n;
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, s0, f0;
        bus.pix_valid = 1'b0;
        bus.pix_data  = '0;
        bus.pix_sof   = 1'b0;
        bus.mem_grant = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_pix_ready", int'(bus.pix_ready), 1);
        chk("rst_mem_en", int'(bus.mem_en), 0);
        chk("rst_mem_rw", int'(bus.mem_rw), 1);
        chk("rst_mem_abus", int'(bus.mem_abus), 0);
        chkw("rst_mem_wdata", bus.mem_wdata, '0);
        chk("rst_row_done", int'(row_done), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_row_idx", int'(row_idx), 0);

        // one row, grant tied high
        @(posedge clk);
        #1;
        bus.mem_grant = 1'b1;
        for (int i = 0; i < ROW_W; i++) send(8'(i), i == 0);
        @(negedge clk);
        chk("t1_latency_mem_en", int'(bus.mem_en), 1);
        chk("t1_mem_rw", int'(bus.mem_rw), 0);
        chk("t1_abus", int'(bus.mem_abus), 0);
        chk("t1_lane49", int'(bus.mem_wdata[8*49 +: 8]), 49);
        drain();

        // two rows with grant held low, then released
        do_reset();
        base = hist_a.size();
        s0 = stalls;
        for (int i = 0; i < 2 * ROW_W; i++) send(8'(i), i == 0);
        chk("t2_no_stall", stalls - s0, 0);
        @(negedge clk);
        chk("t2_ready_low_both_pending", int'(bus.pix_ready), 0);
        chk("t2_mem_en_waiting", int'(bus.mem_en), 1);
        @(posedge clk);
        #1;
        bus.mem_grant = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t2_ready_after_grant", int'(bus.pix_ready), 1);
        chk("t2_gap_mem_en", int'(bus.mem_en), 0);
        drain();
        chk("t2_writes", hist_a.size() - base, 2);
        if (hist_a.size() - base == 2) begin
            chk("t2_row0_abus", int'(hist_a[base]), 0);
            chk("t2_row1_abus", int'(hist_a[base + 1]), 50);
            chk("t2_row1_lane0", int'(hist_d[base + 1][7:0]), 50);
        end

        // full frame plus one row, grant tied high
        do_reset();
        bus.mem_grant = 1'b1;
        base = hist_a.size();
        f0 = fd_cnt;
        for (int i = 0; i < (ROWS + 1) * ROW_W; i++) send(8'(i), i == 0);
        drain();
        chk("t3_writes", hist_a.size() - base, ROWS + 1);
        chk("t3_frame_done_count", fd_cnt - f0, 1);
        chk("t3_frame_done_idx", int'(fd_idx), ROWS - 1);
        if (hist_a.size() - base == ROWS + 1) begin
            chk("t3_row1_abus", int'(hist_a[base + 1]), 50);
            chk("t3_row19_abus", int'(hist_a[base + ROWS - 1]), 950);
            chk("t3_wrap_abus", int'(hist_a[base + ROWS]), 0);
        end

        // partial row discarded by sof
        do_reset();
        bus.mem_grant = 1'b1;
        base = hist_a.size();
        for (int i = 0; i < 30; i++) send(8'(8'h10 + i), 1'b0);
        send(8'hAA, 1'b1);
        for (int i = 0; i < ROW_W - 1; i++) send(8'(8'h80 + i), 1'b0);
        drain();
        chk("t4_writes", hist_a.size() - base, 1);
        if (hist_a.size() - base == 1) begin
            chk("t4_abus", int'(hist_a[base]), 0);
            chk("t4_lane0_sof", int'(hist_d[base][7:0]), 8'hAA);
            chk("t4_lane1", int'(hist_d[base][15:8]), 8'h80);
        end

        // stall in WRITE, then reset mid-burst
        do_reset();
        base = hist_a.size();
        for (int i = 0; i < ROW_W; i++) send(8'(8'hC0 + i), i == 0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("t5_mem_en_held", int'(bus.mem_en), 1);
            chk("t5_abus_stable", int'(bus.mem_abus), 0);
            if (exp_q.size() != 0) chkw("t5_wdata_stable", bus.mem_wdata, exp_q[0].d);
        end
        @(posedge clk);
        #1;
        do_reset();
        @(negedge clk);
        chk("t5_mem_en_after_reset", int'(bus.mem_en), 0);
        chk("t5_mem_rw_after_reset", int'(bus.mem_rw), 1);
        chk("t5_ready_after_reset", int'(bus.pix_ready), 1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("t5_no_row_done", int'(row_done), 0);
        end
        chk("t5_no_write", hist_a.size() - base, 0);

        // grant of row A coincides with last byte of row B
        do_reset();
        base = hist_a.size();
        for (int i = 0; i < ROW_W; i++) send(8'(i + 100), i == 0);
        for (int i = 0; i < ROW_W - 1; i++) send(8'(i + 20), 1'b0);
        bus.pix_valid = 1'b1;
        bus.pix_data  = 8'd77;
        bus.pix_sof   = 1'b0;
        bus.mem_grant = 1'b1;
        @(negedge clk);
        chk("t6_ready_at_last_byte", int'(bus.pix_ready), 1);
        model_accept(8'd77, 1'b0);
        @(posedge clk);
        #1;
        bus.pix_valid = 1'b0;
        @(negedge clk);
        chk("t6_gap_mem_en", int'(bus.mem_en), 0);
        @(negedge clk);
        chk("t6_second_mem_en", int'(bus.mem_en), 1);
        chk("t6_second_abus", int'(bus.mem_abus), 50);
        drain();
        chk("t6_writes", hist_a.size() - base, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
